alu_result_stage: RTL



---
 rtl/alu_result_stage_pkg.sv | 59 +++++
 rtl/alu_result_stage_if.sv | 49 ++++
 rtl/alu_result_stage_sat_counter16.sv | 28 ++
 rtl/alu_result_stage.sv | 105 ++++++++++
 4 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared types, constants and opcode-class helpers for the ALU result stage.
// op_code is op_i[8:1]; the encoding below matches the ALU's opcode map.
package alu_result_stage_pkg;

    localparam int unsigned OP_IN_W = 9;
    localparam int unsigned OP_W    = 8;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 8'h00,
        OP_ADD  = 8'h01,
        OP_ADDC = 8'h02,
        OP_SUB  = 8'h03,
        OP_SUBC = 8'h04,
        OP_LSL  = 8'h05,
        OP_LSLC = 8'h06,
        OP_LSR  = 8'h07,
        OP_LSRC = 8'h08,
        OP_ASR  = 8'h09,
        OP_CMP  = 8'h0A,
        OP_AND  = 8'h0B,
        OP_OR   = 8'h0C,
        OP_NEG  = 8'h0D
    } op_code_e;

    typedef struct packed {
        logic c;
        logic n;
        logic z;
    } flags_t;

    localparam flags_t            FLAGS_RESET = flags_t'(3'b000);
    localparam logic [DATA_W-1:0] ZERO_BYTE   = 8'h00;
    localparam logic [CNT_W-1:0]  CNT_MAX     = 16'hFFFF;

    // Ops that update all three flags from the ALU result and carry.
    function automatic logic op_is_arith(input logic [OP_W-1:0] op_code);
        case (op_code)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_LSL, OP_LSLC,
            OP_LSR, OP_LSRC, OP_ASR, OP_CMP: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    // Ops that update N/Z only; carry is preserved.
    function automatic logic op_is_logic(input logic [OP_W-1:0] op_code);
        case (op_code)
            OP_AND, OP_OR, OP_NEG: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

    // CMP only sets flags; everything else outside the ALU classes writes nothing.
    function automatic logic op_writes_reg(input logic [OP_W-1:0] op_code);
        return (op_is_arith(op_code) || op_is_logic(op_code)) && (op_code != OP_CMP);
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Bus between the ALU / downstream consumers and the result stage.
// slave  : the result stage view.
// master : the environment view (ALU, writeback, branch unit).
// Optional ALU_RESULT_STAGE_PERF_EN adds ops_cnt_o / stall_cnt_o.
interface alu_result_stage_if #(
    parameter int unsigned REG_AW = 3
) ();
    // upstream (ALU side)
    logic              valid_i;
    logic              ready_o;
    logic [8:0]        op_i;
    logic [REG_AW-1:0] rd_i;
    logic [7:0]        result_i;
    logic              carry_i;
    logic              flush_i;
    // downstream (writeback / branch side)
    logic              valid_o;
    logic              ready_i;
    logic [7:0]        result_o;
    logic [REG_AW-1:0] rd_o;
    logic              we_o;
    logic              flag_c_o;
    logic              flag_n_o;
    logic              flag_z_o;
    logic              carry_in_o;
`ifdef ALU_RESULT_STAGE_PERF_EN
    logic [15:0]       ops_cnt_o;
    logic [15:0]       stall_cnt_o;
`endif

    modport slave (
        input  valid_i, op_i, rd_i, result_i, carry_i, flush_i, ready_i,
        output ready_o, valid_o, result_o, rd_o, we_o,
               flag_c_o, flag_n_o, flag_z_o, carry_in_o
`ifdef ALU_RESULT_STAGE_PERF_EN
        , output ops_cnt_o, stall_cnt_o
`endif
    );

    modport master (
        output valid_i, op_i, rd_i, result_i, carry_i, flush_i, ready_i,
        input  ready_o, valid_o, result_o, rd_o, we_o,
               flag_c_o, flag_n_o, flag_z_o, carry_in_o
`ifdef ALU_RESULT_STAGE_PERF_EN
        , input ops_cnt_o, stall_cnt_o
`endif
    );

endinterface

// File: rtl/alu_result_stage_sat_counter16.sv
// 16-bit saturating event counter with enable and synchronous clear.
// Ports: clk_i, rst_ni (async active-low), en_i (count), clr_i (sync clear), cnt_o.
module sat_counter16
    import alu_result_stage_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] r_cnt;

    // Count up on enable, stick at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result pipeline register: captures result/rd/op class from the ALU,
// owns the architectural C/N/Z flags and feeds carry back for chained ops.
// Ports: clk_i, rst_ni (async active-low), bus (alu_result_stage_if.slave):
//   upstream valid_i/ready_o/op_i/rd_i/result_i/carry_i/flush_i,
//   downstream valid_o/ready_i/result_o/rd_o/we_o, flag_{c,n,z}_o, carry_in_o.
// Optional macro ALU_RESULT_STAGE_PERF_EN adds ops_cnt_o and stall_cnt_o.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned REG_AW      = 3,
    parameter logic [2:0]  RESET_FLAGS = 3'b000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    alu_result_stage_if.slave   bus
);

    logic [OP_W-1:0]   w_op_code;
    logic              w_unused_op_lsb;
    logic              w_accept;
    logic              w_is_arith;
    logic              w_is_logic;
    logic              w_writes;

    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic [REG_AW-1:0] r_rd;
    logic              r_writes;
    flags_t            r_flags;

    assign w_op_code       = bus.op_i[OP_IN_W-1:1];
    assign w_unused_op_lsb = bus.op_i[0];
    assign w_is_arith      = op_is_arith(w_op_code);
    assign w_is_logic      = op_is_logic(w_op_code);
    assign w_writes        = op_writes_reg(w_op_code);

    // Ready depends only on the output slot, never on valid_i.
    assign bus.ready_o = ~r_valid | bus.ready_i;
    assign w_accept    = bus.valid_i & bus.ready_o & ~bus.flush_i;

    // Output slot: flush wins, then load, then drain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid  <= 1'b0;
            r_result <= ZERO_BYTE;
            r_rd     <= '0;
            r_writes <= 1'b0;
        end else if (bus.flush_i) begin
            r_valid  <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= bus.result_i;
            r_rd     <= bus.rd_i;
            r_writes <= w_writes;
        end else if (bus.ready_i) begin
            r_valid  <= 1'b0;
        end
    end

    // Flags commit at accept so the next chained op sees the carry one cycle later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_flags <= flags_t'(RESET_FLAGS);
        end else if (w_accept && (w_is_arith || w_is_logic)) begin
            if (w_is_arith) begin
                r_flags.c <= bus.carry_i;
            end
            r_flags.n <= bus.result_i[DATA_W-1];
            r_flags.z <= (bus.result_i == ZERO_BYTE);
        end
    end

    assign bus.valid_o    = r_valid;
    assign bus.result_o   = r_result;
    assign bus.rd_o       = r_rd;
    assign bus.we_o       = r_valid & r_writes;
    assign bus.flag_c_o   = r_flags.c;
    assign bus.flag_n_o   = r_flags.n;
    assign bus.flag_z_o   = r_flags.z;
    assign bus.carry_in_o = r_flags.c;

`ifdef ALU_RESULT_STAGE_PERF_EN
    logic w_stall;

    // A flushed cycle is not counted as a stall.
    assign w_stall = r_valid & ~bus.ready_i & ~bus.flush_i;

    sat_counter16 u_ops_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (w_accept),
        .clr_i  (1'b0),
        .cnt_o  (bus.ops_cnt_o)
    );

    sat_counter16 u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (w_stall),
        .clr_i  (1'b0),
        .cnt_o  (bus.stall_cnt_o)
    );
`endif

endmodule
